// File: rtl/dsp48a1_pkg.sv
// dsp48a1_pkg: shared operand-select encodings and OPMODE layout for the DSP48A1 slice
package dsp48a1_pkg;
    typedef enum logic [1:0] {X_ZERO, X_M, X_P, X_DAB} xsel_e;
    typedef enum logic [1:0] {Z_ZERO, Z_PCIN, Z_P, Z_C} zsel_e;
    localparam int OP_X = 0;
    localparam int OP_Z = 2;
    localparam int OP_CIN = 5;
    localparam int OP_SUB = 7;
    localparam logic [55:0] CIN_OPMODE5 = "OPMODE5";
    localparam logic [55:0] CIN_CARRYIN = "CARRYIN";
endpackage

// File: rtl/post_adder_acc_stage_if.sv
// post_adder_acc_stage_if: operand/result bundle of the post-adder stage
interface post_adder_acc_stage_if #(parameter int WIDTH = 48);
    logic CEP, CECARRYIN, CARRYIN, CARRYOUT, CARRYOUTF;
    logic [7:0] OPMODE;
    logic [35:0] M;
    logic [WIDTH-1:0] DAB, C, PCIN, P, PCOUT;
    modport master (
        output CEP, CECARRYIN, OPMODE, M, DAB, C, PCIN, CARRYIN,
        input P, PCOUT, CARRYOUT, CARRYOUTF
    );
    modport slave (
        input CEP, CECARRYIN, OPMODE, M, DAB, C, PCIN, CARRYIN,
        output P, PCOUT, CARRYOUT, CARRYOUTF
    );
endinterface

// File: rtl/dsp48a1_addsub.sv
// dsp48a1_addsub: Z +/- (X + cin) in WIDTH_2+1 bits; top bit is carry on add, borrow on subtract
module dsp48a1_addsub #(
    parameter int WIDTH_2 = 48,
    parameter logic [15:0] FULLADDER = "ON"
) (
    input  logic [WIDTH_2-1:0] x_i,
    input  logic [WIDTH_2-1:0] z_i,
    input  logic               cin_i,
    input  logic               sub_i,
    output logic [WIDTH_2-1:0] s_o,
    output logic               co_o
);
    logic [WIDTH_2:0] xc, r;
    assign xc = {1'b0, x_i} + {{WIDTH_2{1'b0}}, FULLADDER == "ON" ? cin_i : 1'b0};
    assign r = sub_i ? {1'b0, z_i} - xc : {1'b0, z_i} + xc;
    assign {co_o, s_o} = r;
endmodule

// File: rtl/reg_mux.sv
// reg_mux: optional register with clock enable and sync reset, a plain wire when REG=0
module reg_mux #(
    parameter int W = 1,
    parameter int REG = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         ce_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    if (REG != 0) begin : g_reg
        logic [W-1:0] q_q;
        always_ff @(posedge clk_i)
            if (rst_i) q_q <= '0;
            else if (ce_i) q_q <= d_i;
        assign q_o = q_q;
    end else begin : g_byp
        logic unused_ctl;
        assign unused_ctl = ^{clk_i, rst_i, ce_i};
        assign q_o = d_i;
    end
endmodule

// File: rtl/post_adder_acc_stage.sv
// post_adder_acc_stage: X/Z operand select, carry-in, post-adder and P/CARRYOUT registers
// with P fed back into both muxes for accumulation.
module post_adder_acc_stage
    import dsp48a1_pkg::*;
#(
    parameter int PREG = 1,
    parameter int CARRYINREG = 1,
    parameter int CARRYOUTREG = 1,
    parameter logic [55:0] CARRYINSEL = CIN_OPMODE5,
    parameter int WIDTH = 48
) (
    input logic CLK,
    input logic RST,
    post_adder_acc_stage_if.slave bus
);
    xsel_e x_sel;
    zsel_e z_sel;
    logic [WIDTH-1:0] p_d, p_q, p_fb, x, z;
    logic cin_d, cin, cyo_d, cyo_q, unused;
    assign x_sel = xsel_e'(bus.OPMODE[OP_X +: 2]);
    assign z_sel = zsel_e'(bus.OPMODE[OP_Z +: 2]);
    assign cin_d = CARRYINSEL == CIN_CARRYIN ? bus.CARRYIN : bus.OPMODE[OP_CIN];
    assign unused = ^{bus.OPMODE[6], bus.OPMODE[4], bus.CARRYIN};
    // without a P register the feedback selects read 0 so no combinational loop forms
    assign p_fb = PREG != 0 ? p_q : '0;
    assign x = x_sel == X_ZERO ? '0 : x_sel == X_M ? WIDTH'(bus.M) : x_sel == X_P ? p_fb : bus.DAB;
    assign z = z_sel == Z_ZERO ? '0 : z_sel == Z_PCIN ? bus.PCIN : z_sel == Z_P ? p_fb : bus.C;
    reg_mux #(.W(1), .REG(CARRYINREG)) u_cyi (
        .clk_i(CLK), .rst_i(RST), .ce_i(bus.CECARRYIN), .d_i(cin_d), .q_o(cin)
    );
    dsp48a1_addsub #(.WIDTH_2(WIDTH), .FULLADDER("ON")) u_addsub (
        .x_i(x), .z_i(z), .cin_i(cin), .sub_i(bus.OPMODE[OP_SUB]), .s_o(p_d), .co_o(cyo_d)
    );
    reg_mux #(.W(WIDTH), .REG(PREG)) u_p (
        .clk_i(CLK), .rst_i(RST), .ce_i(bus.CEP), .d_i(p_d), .q_o(p_q)
    );
    reg_mux #(.W(1), .REG(CARRYOUTREG)) u_cyo (
        .clk_i(CLK), .rst_i(RST), .ce_i(bus.CECARRYIN), .d_i(cyo_d), .q_o(cyo_q)
    );
    assign bus.P = p_q;
    assign bus.PCOUT = p_q;
    assign bus.CARRYOUT = cyo_q;
    assign bus.CARRYOUTF = cyo_q;
    if (PREG == 0) begin : g_fb_chk
        always_ff @(posedge CLK)
            assert (RST || (x_sel != X_P && z_sel != Z_P))
            else $warning("P feedback selected while PREG=0; operand reads as 0");
    end
endmodule
